// File: rtl/dsp_mac_seq_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// dsp_mac_seq_ctrl
//
// Control-side initiator for a single DSP48A1 slice. It runs an N-tap
// multiply-accumulate. Samples come in over a valid/ready handshake. The block
// drives the slice's global clock enable, a one-cycle P/M clear and a
// per-sample OPMODE word. That word is delayed so it meets its sample at the
// slice's OPMODE register. A one-cycle done pulse marks the final P result.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start         begin a sequence (sampled in IDLE only)
//   num_taps      tap count, latched when a start is accepted
//   sub           (only with DSP_MAC_SEQ_SUB_EN) subtract mode, latched on start
//   busy          high in every state except IDLE
//   in_valid      source presents a sample on the slice A/B inputs
//   in_ready      block accepts a sample this cycle (decoded from state only)
//   ce            global clock enable for every slice register
//   rstp          synchronous clear for the slice M/P registers
//   opmode        DSP48A1 OPMODE word
//   done          one-cycle pulse, final result is in P
//   result_valid  P holds a completed result
//
// Optional feature macro: DSP_MAC_SEQ_SUB_EN
//   When defined, the block adds a 'sub' input. With sub=1, each accumulate tap
//   subtracts its product from P instead of adding it.
// ---------------------------------------------------------------------------
module dsp_mac_seq_ctrl #(
  parameter int TAP_W      = 8,
  parameter int PIPE_LAT   = 3,
  parameter int OPMODE_DLY = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [TAP_W-1:0] num_taps,
`ifdef DSP_MAC_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ce,
  output logic             rstp,
  output logic [7:0]       opmode,
  output logic             done,
  output logic             result_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } state_t;

  // With OPMODE_DLY=0 the tag goes straight to the port. One storage entry
  // still holds the last tag, so opmode stays steady while the slice is frozen.
  localparam int DEPTH   = (OPMODE_DLY < 1) ? 1 : OPMODE_DLY;
  localparam int DRAIN_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT);

  // OPMODE encodings: X selects the multiplier and Z selects P or zero.
  // Bit 7 is the post-adder subtract.
  localparam logic [7:0] TAG_FIRST  = 8'h01;
  localparam logic [7:0] TAG_ACC    = 8'h09;
  localparam logic [7:0] TAG_SUB    = 8'h89;
  localparam logic [7:0] TAG_BUBBLE = 8'h08;

  state_t             state_q;
  logic [TAP_W-1:0]   numTaps_q;
  logic [TAP_W-1:0]   tapCnt_q;
  logic [DRAIN_W-1:0] drainCnt_q;
  logic               busy_q;
  logic               rstp_q;
  logic               done_q;
  logic               resultValid_q;
  logic [7:0]         align_q [DEPTH];

  logic               startAcc;
  logic               accept;
  logic               lastTap;
  logic               subMode;
  logic [7:0]         tag_d;

  // Handshake decode. in_ready depends only on state, so a source may use it
  // to form in_valid without creating a combinational loop.
  assign startAcc = (state_q == IDLE) && start && (num_taps != '0);
  assign in_ready = (state_q == RUN);
  assign accept   = in_ready && in_valid;
  assign lastTap  = (tapCnt_q == (numTaps_q - TAP_W'(1)));

  // The slice advances only when a sample enters or the pipeline is draining.
  // In every other cycle, P and all in-flight products are frozen.
  assign ce = accept || (state_q == DRAIN);

`ifdef DSP_MAC_SEQ_SUB_EN
  logic subMode_q;

  // Subtract mode is captured with the tap count and held for the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      subMode_q <= 1'b0;
    end else if (startAcc) begin
      subMode_q <= sub;
    end
  end

  assign subMode = subMode_q;
`else
  assign subMode = 1'b0;
`endif

  // Tag for the sample entering this cycle. The first tap loads P with the
  // product (Z=0). Later taps accumulate onto P. Drain bubbles hold P
  // (X=0, Z=P) and let the last products ripple through.
  always_comb begin
    tag_d = TAG_BUBBLE;
    if (state_q == RUN) begin
      if (tapCnt_q == '0) begin
        tag_d = TAG_FIRST;
      end else if (subMode) begin
        tag_d = TAG_SUB;
      end else begin
        tag_d = TAG_ACC;
      end
    end
  end

  // Alignment shift register. It moves on the same enabled edges as the slice,
  // so each tag keeps a fixed distance from its sample however the stream stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        align_q[i] <= 8'h00;
      end
    end else if (ce) begin
      align_q[0] <= tag_d;
      for (int i = 1; i < DEPTH; i++) begin
        align_q[i] <= align_q[i-1];
      end
    end
  end

  generate
    if (OPMODE_DLY == 0) begin : gOpComb
      assign opmode = ce ? tag_d : align_q[0];
    end else begin : gOpReg
      assign opmode = align_q[DEPTH-1];
    end
  endgenerate

  // Sequencer FSM with registered status outputs. rstp and done are
  // single-cycle pulses, so they default low every cycle.
  // busy and result_valid are set and cleared on the transitions that enter
  // and leave the matching states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      numTaps_q     <= '0;
      tapCnt_q      <= '0;
      drainCnt_q    <= '0;
      busy_q        <= 1'b0;
      rstp_q        <= 1'b0;
      done_q        <= 1'b0;
      resultValid_q <= 1'b0;
    end else begin
      rstp_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (startAcc) begin
            numTaps_q     <= num_taps;
            tapCnt_q      <= '0;
            resultValid_q <= 1'b0;
            rstp_q        <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= CLR;
          end
        end
        CLR: begin
          state_q <= RUN;
        end
        RUN: begin
          if (accept) begin
            tapCnt_q <= tapCnt_q + TAP_W'(1);
            if (lastTap) begin
              if (PIPE_LAT == 1) begin
                done_q        <= 1'b1;
                resultValid_q <= 1'b1;
                state_q       <= DONE;
              end else begin
                drainCnt_q <= DRAIN_W'(PIPE_LAT - 1);
                state_q    <= DRAIN;
              end
            end
          end
        end
        DRAIN: begin
          drainCnt_q <= drainCnt_q - DRAIN_W'(1);
          if (drainCnt_q == DRAIN_W'(1)) begin
            done_q        <= 1'b1;
            resultValid_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign rstp         = rstp_q;
  assign done         = done_q;
  assign result_valid = resultValid_q;

endmodule

// File: tb/tb_dsp_mac_seq_ctrl.sv
`timescale 1ns/1ps
// Testbench for dsp_mac_seq_ctrl.
// Instance A uses PIPE_LAT=3 and OPMODE_DLY=1. Instance B uses PIPE_LAT=1 and
// OPMODE_DLY=0. The expected waveforms are derived from the cycle numbers of
// accepted samples: acceptance window, drain length, done position, and the
// tag history delayed by OPMODE_DLY enabled edges.
module tb_dsp_mac_seq_ctrl;

  localparam int A_LAT = 3;
  localparam int A_DLY = 1;
  localparam int B_LAT = 1;
  localparam int B_DLY = 0;

  logic       clk = 1'b0;
  logic       reset;
  logic       aStart, aValid, bStart, bValid;
  logic [7:0] aNum, bNum;
`ifdef DSP_MAC_SEQ_SUB_EN
  logic       aSub, bSub;
`endif
  logic       aBusy, aReady, aCe, aRstp, aDone, aRv;
  logic       bBusy, bReady, bCe, bRstp, bDone, bRv;
  logic [7:0] aOp, bOp;

  int checks = 0;
  int fails  = 0;

  bit         validVec [64];
  bit         startVec [64];
  logic [7:0] histA [$];
  logic [7:0] histB [$];
  bit         prevRvA = 1'b0;
  bit         prevRvB = 1'b0;

  dsp_mac_seq_ctrl #(.TAP_W(8), .PIPE_LAT(A_LAT), .OPMODE_DLY(A_DLY)) dutA (
    .clk(clk), .reset(reset), .start(aStart), .num_taps(aNum),
`ifdef DSP_MAC_SEQ_SUB_EN
    .sub(aSub),
`endif
    .busy(aBusy), .in_valid(aValid), .in_ready(aReady), .ce(aCe),
    .rstp(aRstp), .opmode(aOp), .done(aDone), .result_valid(aRv)
  );

  dsp_mac_seq_ctrl #(.TAP_W(8), .PIPE_LAT(B_LAT), .OPMODE_DLY(B_DLY)) dutB (
    .clk(clk), .reset(reset), .start(bStart), .num_taps(bNum),
`ifdef DSP_MAC_SEQ_SUB_EN
    .sub(bSub),
`endif
    .busy(bBusy), .in_valid(bValid), .in_ready(bReady), .ce(bCe),
    .rstp(bRstp), .opmode(bOp), .done(bDone), .result_valid(bRv)
  );

  always #5 clk = ~clk;

  // One sequence on instance sel (0=A, 1=B). start is raised in cycle 0.
  // validVec and startVec (extra start pulses) are indexed by cycle.
  task automatic runTxn(input int sel, input int nTaps, input bit subV, input string tag);
    int         acc [$];
    logic [7:0] h [$];
    int         lat, dly, last, doneC, k;
    bit         isAcc, eCe, eBusy, eRstp, eReady, eDone, eRv, prevRv;
    logic [7:0] curTag, eOp;
    logic       oBusy, oReady, oCe, oRstp, oDone, oRv;
    logic [7:0] oOp;
    string      nm;
    lat    = sel ? B_LAT : A_LAT;
    dly    = sel ? B_DLY : A_DLY;
    h      = sel ? histB : histA;
    prevRv = sel ? prevRvB : prevRvA;
    nm     = {sel ? "B." : "A.", tag};
    for (int c = 2; c < 64; c++) begin
      if (validVec[c] && acc.size() < nTaps) acc.push_back(c);
    end
    last  = acc[nTaps-1];
    doneC = last + lat;
    for (int c = 0; c < doneC + 3; c++) begin
      @(negedge clk);
      if (sel == 0) begin
        aStart = (c == 0) || (startVec[c] && c >= 1 && c <= doneC);
        aNum   = (c == 0) ? 8'(nTaps) : 8'($urandom_range(0, 255));
        aValid = validVec[c];
`ifdef DSP_MAC_SEQ_SUB_EN
        aSub   = (c == 0) ? subV : ~subV;
`endif
      end else begin
        bStart = (c == 0) || (startVec[c] && c >= 1 && c <= doneC);
        bNum   = (c == 0) ? 8'(nTaps) : 8'($urandom_range(0, 255));
        bValid = validVec[c];
`ifdef DSP_MAC_SEQ_SUB_EN
        bSub   = (c == 0) ? subV : ~subV;
`endif
      end
      #1;
      isAcc = 1'b0;
      k     = 0;
      for (int j = 0; j < acc.size(); j++) begin
        if (acc[j] == c) begin
          isAcc = 1'b1;
          k     = j;
        end
      end
      eCe    = isAcc || (c > last && c < doneC);
      curTag = !isAcc ? 8'h08 : (k == 0) ? 8'h01 : (subV ? 8'h89 : 8'h09);
      if (dly == 0) eOp = eCe ? curTag : ((h.size() > 0) ? h[h.size()-1] : 8'h00);
      else          eOp = (h.size() >= dly) ? h[h.size()-dly] : 8'h00;
      eBusy  = (c >= 1) && (c <= doneC);
      eRstp  = (c == 1);
      eReady = (c >= 2) && (c <= last);
      eDone  = (c == doneC);
      eRv    = (c == 0) ? prevRv : (c >= doneC);
      oBusy  = sel ? bBusy  : aBusy;
      oReady = sel ? bReady : aReady;
      oCe    = sel ? bCe    : aCe;
      oRstp  = sel ? bRstp  : aRstp;
      oDone  = sel ? bDone  : aDone;
      oRv    = sel ? bRv    : aRv;
      oOp    = sel ? bOp    : aOp;
      checks++; if (oBusy !== eBusy) begin fails++; $display("[TB] FAIL %s.busy cyc=%0d got=%b exp=%b", nm, c, oBusy, eBusy); end
      checks++; if (oReady !== eReady) begin fails++; $display("[TB] FAIL %s.in_ready cyc=%0d got=%b exp=%b", nm, c, oReady, eReady); end
      checks++; if (oCe !== eCe) begin fails++; $display("[TB] FAIL %s.ce cyc=%0d got=%b exp=%b", nm, c, oCe, eCe); end
      checks++; if (oRstp !== eRstp) begin fails++; $display("[TB] FAIL %s.rstp cyc=%0d got=%b exp=%b", nm, c, oRstp, eRstp); end
      checks++; if (oDone !== eDone) begin fails++; $display("[TB] FAIL %s.done cyc=%0d got=%b exp=%b", nm, c, oDone, eDone); end
      checks++; if (oRv !== eRv) begin fails++; $display("[TB] FAIL %s.result_valid cyc=%0d got=%b exp=%b", nm, c, oRv, eRv); end
      checks++; if (oOp !== eOp) begin fails++; $display("[TB] FAIL %s.opmode cyc=%0d got=%h exp=%h", nm, c, oOp, eOp); end
      if (eCe) h.push_back(curTag);
    end
    if (sel == 0) begin
      histA = h; prevRvA = 1'b1; aStart = 1'b0; aValid = 1'b0;
    end else begin
      histB = h; prevRvB = 1'b1; bStart = 1'b0; bValid = 1'b0;
    end
  endtask

  task automatic fillVectors(input bit allValid);
    for (int c = 0; c < 64; c++) begin
      validVec[c] = allValid;
      startVec[c] = 1'b0;
    end
  endtask

  // Checks every output of both instances while reset is asserted.
  task automatic checkAllZero(input string tag);
    checks++; if ({aBusy, aReady, aCe, aRstp, aDone, aRv} !== 6'b0) begin fails++; $display("[TB] FAIL %s.A_ctrl got=%b exp=000000", tag, {aBusy, aReady, aCe, aRstp, aDone, aRv}); end
    checks++; if (aOp !== 8'h00) begin fails++; $display("[TB] FAIL %s.A_opmode got=%h exp=00", tag, aOp); end
    checks++; if ({bBusy, bReady, bCe, bRstp, bDone, bRv} !== 6'b0) begin fails++; $display("[TB] FAIL %s.B_ctrl got=%b exp=000000", tag, {bBusy, bReady, bCe, bRstp, bDone, bRv}); end
    checks++; if (bOp !== 8'h00) begin fails++; $display("[TB] FAIL %s.B_opmode got=%h exp=00", tag, bOp); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    checkAllZero("reset");
    @(negedge clk);
    reset = 1'b0;
    histA.delete(); histB.delete();
    prevRvA = 1'b0; prevRvB = 1'b0;
  endtask

  task automatic test_stream();
    fillVectors(1'b1);
    runTxn(0, 4, 1'b0, "stream");
  endtask

  task automatic test_stall();
    fillVectors(1'b1);
    validVec[3] = 1'b0;
    validVec[4] = 1'b0;
    runTxn(0, 4, 1'b0, "stall");
  endtask

  task automatic test_single_tap();
    fillVectors(1'b1);
    runTxn(1, 1, 1'b0, "single");
    fillVectors(1'b1);
    validVec[3] = 1'b0;
    runTxn(1, 3, 1'b0, "b_multi");
  endtask

  task automatic test_ignored();
    // A zero tap count must not start anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      aStart = 1'b1;
      aNum   = 8'd0;
      aValid = 1'b1;
      #1;
      checks++; if (aBusy !== 1'b0) begin fails++; $display("[TB] FAIL zero_taps.busy i=%0d got=%b exp=0", i, aBusy); end
      checks++; if (aRstp !== 1'b0) begin fails++; $display("[TB] FAIL zero_taps.rstp i=%0d got=%b exp=0", i, aRstp); end
      checks++; if (aRv !== prevRvA) begin fails++; $display("[TB] FAIL zero_taps.result_valid i=%0d got=%b exp=%b", i, aRv, prevRvA); end
    end
    aStart = 1'b0;
    aValid = 1'b0;
    // Start pulses during RUN and DRAIN must be ignored.
    fillVectors(1'b1);
    startVec[3] = 1'b1;
    startVec[6] = 1'b1;
    startVec[7] = 1'b1;
    runTxn(0, 4, 1'b0, "start_in_busy");
  endtask

  task automatic test_back_to_back();
    fillVectors(1'b1);
    runTxn(0, 2, 1'b0, "b2b_1");
    runTxn(0, 3, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    int  sel, n;
    bit  subV;
    for (int it = 0; it < 10; it++) begin
      sel  = int'($urandom_range(0, 1));
      n    = int'($urandom_range(1, 6));
      subV = 1'b0;
`ifdef DSP_MAC_SEQ_SUB_EN
      subV = 1'($urandom_range(0, 1));
`endif
      for (int c = 0; c < 64; c++) begin
        validVec[c] = (c >= 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
        startVec[c] = ($urandom_range(0, 7) == 0);
      end
      runTxn(sel, n, subV, "random");
    end
  endtask

`ifdef DSP_MAC_SEQ_SUB_EN
  task automatic test_sub();
    fillVectors(1'b1);
    runTxn(0, 3, 1'b1, "sub1");
    runTxn(0, 3, 1'b0, "sub0");
    runTxn(1, 3, 1'b1, "b_sub1");
  endtask
`endif

  task automatic test_reset_mid_run();
    @(negedge clk);
    aStart = 1'b1;
    aNum   = 8'd4;
    aValid = 1'b1;
    @(negedge clk);
    aStart = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (aReady !== 1'b1) begin fails++; $display("[TB] FAIL mid_run.in_ready got=%b exp=1", aReady); end
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("mid_run_reset");
    histA.delete(); histB.delete();
    prevRvA = 1'b0; prevRvB = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (aBusy !== 1'b0) begin fails++; $display("[TB] FAIL post_reset.busy i=%0d got=%b exp=0", i, aBusy); end
      checks++; if (aDone !== 1'b0) begin fails++; $display("[TB] FAIL post_reset.done i=%0d got=%b exp=0", i, aDone); end
      checks++; if (aCe !== 1'b0) begin fails++; $display("[TB] FAIL post_reset.ce i=%0d got=%b exp=0", i, aCe); end
    end
    aValid = 1'b0;
  endtask

  initial begin
    aStart = 1'b0; aValid = 1'b0; aNum = 8'd0;
    bStart = 1'b0; bValid = 1'b0; bNum = 8'd0;
`ifdef DSP_MAC_SEQ_SUB_EN
    aSub = 1'b0; bSub = 1'b0;
`endif
    test_reset();
    test_stream();
    test_stall();
    test_single_tap();
    test_ignored();
    test_back_to_back();
`ifdef DSP_MAC_SEQ_SUB_EN
    test_sub();
`endif
    test_random();
    test_reset_mid_run();
    fillVectors(1'b1);
    runTxn(0, 2, 1'b0, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/dsp_mac_seq_ctrl.md
Name: dsp_mac_seq_ctrl

Overview:
- Control-side initiator for one DSP48A1 slice.
- The slice's registered control stages (OPMODE, CE, RSTP capture registers) are the receiving end; this block generates what they receive.
- Sequences an N-tap multiply-accumulate: accepts samples via valid/ready, drives the global clock enable, the P-clear pulse and a per-sample OPMODE word aligned to the slice pipeline, then flags the final P result.
- Sits between the sample source (FIR/correlator front-end) and the slice wrapper.

Parameters:
- TAP_W, 8, width of tap count and internal tap counter.
- PIPE_LAT, 3, enabled clock edges from sample-accept edge until P holds that sample's contribution (min 1).
- OPMODE_DLY, 1, enabled edges the OPMODE tag lags sample acceptance (0..4); 0 = tag driven combinationally.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin sequence; sampled in IDLE only.
- num_taps  in  TAP_W  tap count, latched on accepted start.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  source has a sample on slice A/B inputs.
- in_ready  out  1  block accepts a sample this cycle.
- ce  out  1  global clock enable to all slice registers.
- rstp  out  1  synchronous clear to slice M/P registers.
- opmode  out  8  DSP48A1 OPMODE word to slice.
- done  out  1  one-cycle pulse, final result in P.
- result_valid  out  1  P holds a completed result.

Behaviour:
- Reset (async, immediate, any state): state=IDLE; busy, in_ready, ce, rstp, done, result_valid = 0; opmode = 8'h00; alignment shift register = all 8'h00; counters = 0.
- States: IDLE, CLR, RUN, DRAIN, DONE.
- IDLE:
  - start=1 with num_taps!=0: latch num_taps, tap_cnt=0, clear result_valid, go to CLR.
  - start with num_taps==0: ignored.
- CLR (1 cycle): rstp=1, ce=0, in_ready=0; next state RUN.
- RUN:
  - in_ready=1; ce = in_valid (accept = in_valid & in_ready).
  - On accept: push tag into alignment register; tag = 8'h01 (X=multiplier, Z=0) if tap_cnt==0, else 8'h09 (X=multiplier, Z=P); tap_cnt++.
  - No accept: ce=0, whole slice and alignment register frozen.
  - Accept with tap_cnt==num_taps-1: if PIPE_LAT==1 go to DONE, else go to DRAIN with drain_cnt=PIPE_LAT-1.
- DRAIN:
  - in_ready=0, ce=1 every cycle; push bubble tag 8'h08 (X=0, Z=P, hold).
  - drain_cnt-- each cycle; at drain_cnt==1 go to DONE.
- DONE (1 cycle): ce=0, done=1, result_valid=1; next state IDLE.
- result_valid stays 1 in IDLE (P frozen, ce=0) until the next accepted start.
- opmode = oldest entry of the OPMODE_DLY-deep shift register; the register advances only on ce=1.
- start asserted outside IDLE: ignored; no state or counter change.
- in_ready is combinational from state only (no dependence on in_valid).
- All other outputs except ce and in_ready are registered.

Optional Feature:
- Macro: DSP_MAC_SEQ_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched on accepted start.
  - sub=1: accumulate tag becomes 8'h89 (post-adder subtract, P minus product); first-tap tag stays 8'h01; bubble tag stays 8'h08.
- Undefined: no sub port; tags fixed as in Behaviour.

Test Plan:
- Reset: assert reset mid-cycle in RUN, then release -> all outputs 0 and opmode=8'h00 immediately, state IDLE, no done.
- Continuous stream (PIPE_LAT=3, OPMODE_DLY=1, num_taps=4, in_valid=1): start at c0 -> rstp=1 at c1; in_ready at c2-c5; opmode 01,09,09,09 at c3-c6; DRAIN c6-c7; done=1 at c8; result_valid from c8, held in IDLE.
- Stall (same setup, in_valid=0 at c3-c4): ce=0 and opmode held at 8'h01 during c3-c4 -> done shifted to c10; tag sequence unchanged.
- Single tap (num_taps=1, PIPE_LAT=1) -> one accept with opmode tag 8'h01; DONE the next cycle; no DRAIN cycles.
- Ignored requests: start with num_taps=0 -> busy stays 0; start pulsed during DRAIN -> no restart, tap count unaffected, exactly one done.
- DSP_MAC_SEQ_SUB_EN defined, sub=1, num_taps=3 -> opmode tags 01,89,89; sub=0 -> 01,09,09.
